// File: rtl/pulse_train_pkg.sv
// State encodings for the pulse line, shared by the pulse generator and the decoder.
package pulse_train_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HIGH = 2'b01,
    GAP  = 2'b10
  } state_t;

endpackage

// File: rtl/pulse_train_decoder_input_sync2.sv
// Two-flop synchronizer for an asynchronous pulse line; both stages reset to 0.
module input_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pulse_train_decoder.sv
// Pulse train decoder: validates pulse widths, counts a burst, reports it after a low gap.
// Define PULSE_SYNC_EN to pass pulse_in through a 2-flop synchronizer (adds 2 cycles latency).
//
// state | meaning
// IDLE  | no burst in progress, waiting for the line to rise
// HIGH  | line high, measuring pulse width
// GAP   | line low after a valid pulse, timing the gap
module pulse_train_decoder
  import pulse_train_pkg::*;
#(
  parameter int WIDTH_MIN   = 2,
  parameter int WIDTH_MAX   = 3,
  parameter int GAP_TIMEOUT = 16,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pulse_in,
  output logic [CNT_W-1:0] count_out,
  output logic             count_valid,
  output logic             width_err,
  output logic             busy
);

  localparam int W_W = $clog2(WIDTH_MAX + 2);
  localparam int G_W = $clog2(GAP_TIMEOUT + 1);

  localparam logic [W_W-1:0] W_LO   = W_W'(WIDTH_MIN);
  localparam logic [W_W-1:0] W_HI   = W_W'(WIDTH_MAX);
  localparam logic [W_W-1:0] W_SAT  = W_W'(WIDTH_MAX + 1);
  localparam logic [G_W-1:0] G_LAST = G_W'(GAP_TIMEOUT - 1);

  logic             pulse_s;
  state_t           state;
  logic [W_W-1:0]   width;
  logic [G_W-1:0]   gap;
  logic [CNT_W-1:0] burst;

`ifdef PULSE_SYNC_EN
  input_sync2 u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (pulse_in),
    .q     (pulse_s)
  );
`else
  assign pulse_s = pulse_in;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      width       <= '0;
      gap         <= '0;
      burst       <= '0;
      count_out   <= '0;
      count_valid <= 1'b0;
      width_err   <= 1'b0;
    end else begin
      count_valid <= 1'b0;
      width_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (pulse_s) begin
            state <= HIGH;
            width <= W_W'(1);
          end
        end
        HIGH: begin
          if (pulse_s) begin
            if (width != W_SAT) width <= width + 1'b1;
          end else if (width >= W_LO && width <= W_HI) begin
            if (burst != '1) burst <= burst + 1'b1;
            gap   <= G_W'(1);
            state <= GAP;
          end else begin
            width_err <= 1'b1;
            burst     <= '0;
            state     <= IDLE;
          end
        end
        GAP: begin
          if (pulse_s) begin
            state <= HIGH;
            width <= W_W'(1);
          end else if (gap == G_LAST) begin
            // this sample is the GAP_TIMEOUT-th consecutive low
            count_out   <= burst;
            count_valid <= 1'b1;
            burst       <= '0;
            state       <= IDLE;
          end else begin
            gap <= gap + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_pulse_train_decoder.sv
// Scoreboard bench for pulse_train_decoder: segment-level reference model vs. observed strobes.
module tb_pulse_train_decoder;

  localparam int WMIN = 2;
  localparam int WMAX = 3;
  localparam int GAPT = 16;
  localparam int CMAX = 15;
`ifdef PULSE_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pulse_in = 1'b0;
  logic [3:0] count_out;
  logic       count_valid;
  logic       width_err;
  logic       busy;

  pulse_train_decoder dut (
    .clk         (clk),
    .reset       (reset),
    .pulse_in    (pulse_in),
    .count_out   (count_out),
    .count_valid (count_valid),
    .width_err   (width_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int     kind;   // 1 = count_valid, 2 = width_err
    int     cnt;
    longint t;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   m_burst = 0;

  task automatic check(input string name, input bit ok, input longint act, input longint req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
  endtask

  // Reference: a pulse of h highs followed by l lows, h samples starting at edge 'start'.
  task automatic model_seg(input int h, input int l, input longint start);
    exp_t e;
    longint fall;
    fall = start + h;
    if (h >= WMIN && h <= WMAX) begin
      if (m_burst < CMAX) m_burst++;
      if (l >= GAPT) begin
        e.kind = 1; e.cnt = m_burst; e.t = fall + GAPT - 1 + LAT;
        exp_q.push_back(e);
        m_burst = 0;
      end
    end else begin
      e.kind = 2; e.cnt = 0; e.t = fall + LAT;
      exp_q.push_back(e);
      m_burst = 0;
    end
  endtask

  task automatic seg(input int h, input int l);
    @(negedge clk);
    model_seg(h, l, cyc + 1);
    pulse_in = 1'b1;
    repeat (h - 1) @(negedge clk);
    @(negedge clk);
    pulse_in = 1'b0;
    repeat (l - 1) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    pulse_in = 1'b0;
    m_burst = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: pops an expectation whenever the DUT presents a strobe.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && (count_valid || width_err)) begin
        check("strobe_exclusive", !(count_valid && width_err), {count_valid, width_err}, 0);
        check("busy_at_strobe", busy == 1'b0, busy, 0);
        check("strobe_expected", exp_q.size() != 0, 1, exp_q.size());
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("strobe_kind", (count_valid ? 1 : 2) == e.kind, count_valid ? 1 : 2, e.kind);
          check("strobe_time", cyc == e.t, cyc, e.t);
          if (e.kind == 1) check("count_out", int'(count_out) == e.cnt, count_out, e.cnt);
        end
      end
    end
  end

  initial begin
    int h, l, sel;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset_count_out", count_out == 4'd0, count_out, 0);
    check("reset_count_valid", count_valid == 1'b0, count_valid, 0);
    check("reset_width_err", width_err == 1'b0, width_err, 0);
    check("reset_busy", busy == 1'b0, busy, 0);

    // 1: three 2-cycle pulses, 3-cycle gaps
    seg(2, 3); seg(2, 3); seg(2, 20);
    // 2: 1-cycle pulse
    seg(1, 20);
    // 3: too-wide pulse, then a valid one
    seg(5, 20); seg(2, 20);
    // 4: saturation
    for (int i = 0; i < 19; i++) seg(2, 2);
    seg(2, 20);
    // line held high a long time
    seg(40, 20);
    // 5: reset mid-burst discards it
    seg(2, 3); seg(2, 5);
    check("busy_mid_burst", busy == 1'b1, busy, 1);
    do_reset();
    #1;
    check("reset_clears_count_out", count_out == 4'd0, count_out, 0);
    check("reset_clears_busy", busy == 1'b0, busy, 0);
    seg(2, 20);
    // 6: gap boundary
    seg(2, GAPT - 1); seg(2, 20);
    seg(2, GAPT); seg(2, 20);

    for (int i = 0; i < 200; i++) begin
      h = $urandom_range(1, 6);
      sel = $urandom_range(0, 3);
      l = (sel == 0) ? $urandom_range(GAPT - 1, GAPT + 1) : $urandom_range(1, 20);
      seg(h, l);
    end
    seg(2, 30);

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", exp_q.size() == 0, exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
